paddle_motion_controller: RTL

Parametrised N-paddle motion engine for the Pong game core, replacing the single-paddle controller. It runs one direction/velocity state machine per paddle, ramps speed while a button is held, and clamps each paddle exactly against the ceiling and floor limits. Outputs are registered positions consumed by the collision checker and the video renderer; everything is updated once per `game_clk` tick.

---
 rtl/paddle_motion_if.sv | 38 +++
 rtl/paddle_motion_controller.sv | 84 ++++++++
 2 files changed

// File: rtl/paddle_motion_if.sv
// paddle_motion_if: control/status bundle between the game core and the paddle motion engine.
// master drives buttons, playfield limits, paddle height and velocity cap, and reads packed
// paddle_y/paddle_x/paddle_vel/at_limit. slave is the engine's side.
// With PADDLE_AI_EN defined it also carries ai_enable and ball_y.
interface paddle_motion_if #(
  parameter int N_PADDLES = 2,
  parameter int COORD_W = 10,
  parameter int VEL_W = 4
);
  logic [N_PADDLES-1:0] input_up;
  logic [N_PADDLES-1:0] input_down;
  logic [COORD_W-1:0] y_ceil;
  logic [COORD_W-1:0] y_floor;
  logic [7:0] height_paddle;
  logic [VEL_W-1:0] vel_max;
  logic [N_PADDLES*COORD_W-1:0] paddle_y;
  logic [N_PADDLES*COORD_W-1:0] paddle_x;
  logic [N_PADDLES*VEL_W-1:0] paddle_vel;
  logic [N_PADDLES-1:0] at_limit;
`ifdef PADDLE_AI_EN
  logic [N_PADDLES-1:0] ai_enable;
  logic [COORD_W-1:0] ball_y;
`endif
  modport master(
    output input_up, input_down, y_ceil, y_floor, height_paddle, vel_max,
`ifdef PADDLE_AI_EN
    output ai_enable, ball_y,
`endif
    input paddle_y, paddle_x, paddle_vel, at_limit
  );
  modport slave(
    input input_up, input_down, y_ceil, y_floor, height_paddle, vel_max,
`ifdef PADDLE_AI_EN
    input ai_enable, ball_y,
`endif
    output paddle_y, paddle_x, paddle_vel, at_limit
  );
endinterface

// File: rtl/paddle_motion_controller.sv
// paddle_motion_controller: N-paddle motion engine with per-paddle IDLE/UP/DOWN FSM, speed ramp
// while a button is held, and exact clamping against ceiling/floor.
// Ports: game_clk, reset (sync, active-low), bus (paddle_motion_if.slave).
// Optional macro PADDLE_AI_EN: paddles with ai_enable set track ball_y instead of buttons.
module paddle_motion_controller #(
  parameter int N_PADDLES = 2,
  parameter int COORD_W = 10,
  parameter int VEL_W = 4,
  parameter int Y_INIT = 200,
  parameter int X_LEFT = 20,
  parameter int X_RIGHT = 610,
  parameter int MARGIN = 0,
  parameter int ACCEL_TICKS = 8
) (
  input logic game_clk,
  input logic reset,
  paddle_motion_if.slave bus
);
  localparam int W = COORD_W + 2;
  localparam int CW = $clog2(ACCEL_TICKS + 1);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  logic signed [W-1:0] top, bot;
  logic degen;
  logic [VEL_W-1:0] vel1;
  assign top = $signed({2'b0, bus.y_ceil}) + W'(MARGIN);
  assign bot = $signed({2'b0, bus.y_floor}) - $signed({{(W-8){1'b0}}, bus.height_paddle}) - W'(MARGIN);
  assign degen = bot < top;
  assign vel1 = VEL_W'(bus.vel_max != '0);
  for (genvar i = 0; i < N_PADDLES; i++) begin : g_p
    state_t state, state_n, cmd;
    logic [VEL_W-1:0] vel, vel_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [COORD_W-1:0] y;
    logic lim, lim_n, up, dn, hold, step;
    logic signed [W-1:0] ys, vs, yu, yd, y_w;
    assign ys = $signed({2'b0, y});
`ifdef PADDLE_AI_EN
    logic signed [W-1:0] ctr, ball;
    // Dead band of +-4 px around the paddle center keeps the AI from jittering.
    assign ctr = ys + $signed({{(W-7){1'b0}}, bus.height_paddle[7:1]});
    assign ball = $signed({2'b0, bus.ball_y});
    assign up = bus.ai_enable[i] ? ball < ctr - W'(4) : bus.input_up[i];
    assign dn = bus.ai_enable[i] ? ball > ctr + W'(4) : bus.input_down[i];
`else
    assign up = bus.input_up[i];
    assign dn = bus.input_down[i];
`endif
    always_comb begin
      cmd = up & ~dn ? UP : dn & ~up ? DOWN : IDLE;
      state_n = cmd;
      hold = cmd != IDLE && cmd == state;
      step = cnt == CW'(ACCEL_TICKS - 1);
      cnt_n = hold && !step ? cnt + 1'b1 : '0;
      vel_n = cmd == IDLE ? '0 : !hold ? vel1 :
              step ? (vel >= bus.vel_max ? bus.vel_max : vel + 1'b1) :
              (vel > bus.vel_max ? bus.vel_max : vel);
      // Move with the velocity chosen this same edge, so the first pressed tick moves 1 px.
      vs = $signed({{(W-VEL_W){1'b0}}, vel_n});
      yu = ys - vs;
      yd = ys + vs;
      y_w = degen ? top : cmd == UP ? (yu < top ? top : yu) : cmd == DOWN ? (yd > bot ? bot : yd) : ys;
      lim_n = degen | (cmd == UP && y_w == top) | (cmd == DOWN && y_w == bot);
    end
    always_ff @(posedge game_clk) begin
      if (!reset) begin
        state <= IDLE;
        vel <= '0;
        cnt <= '0;
        y <= COORD_W'(Y_INIT);
        lim <= 1'b0;
      end else begin
        state <= state_n;
        vel <= vel_n;
        cnt <= cnt_n;
        y <= y_w[COORD_W-1:0];
        lim <= lim_n;
      end
    end
    assign bus.paddle_y[i*COORD_W +: COORD_W] = y;
    assign bus.paddle_x[i*COORD_W +: COORD_W] = COORD_W'(i % 2 ? X_RIGHT : X_LEFT);
    assign bus.paddle_vel[i*VEL_W +: VEL_W] = vel;
    assign bus.at_limit[i] = lim;
  end
endmodule
